axil_cmd_master: RTL and testbench

- Single-outstanding AXI-Lite initiator. It converts a simple valid/ready command stream (read or write, one 32-bit word) into AXI-Lite transactions.
- It returns each completion on a valid/ready response stream.
- It drives AXI-Lite responders such as the team's RAM and register blocks, from test sequencers, boot loaders and bridge logic.
- It includes a sticky watchdog flag for hung responders.

---
 rtl/axil_pkg.sv | 18 +
 rtl/axil_cmd_master.sv | 223 ++++++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: response codes and the command-master state encoding.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WB,
        ST_RA,
        ST_RD,
        ST_RSP
    } state_e;

endpackage

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-Lite initiator: one command in, one AXI-Lite transaction out,
// one response back, with a sticky watchdog flag for responders that never answer.
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int TIMEOUT_W = 12
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic              cmdWrite,
    input  logic [ADDR_W-1:0] cmdAddr,
    input  logic [31:0]       cmdData,
    input  logic [3:0]        cmdStrb,
    output logic              rspValid,
    input  logic              rspReady,
    output logic [31:0]       rspData,
    output logic [1:0]        rspResp,
    output logic              errTimeout,
    input  logic              errClr,
    output logic              awValid,
    input  logic              awReady,
    output logic [ADDR_W-1:0] awAddr,
    output logic              wValid,
    input  logic              wReady,
    output logic [31:0]       wData,
    output logic [3:0]        wStrb,
    input  logic              bValid,
    output logic              bReady,
    input  logic [1:0]        bResp,
    output logic              arValid,
    input  logic              arReady,
    output logic [ADDR_W-1:0] arAddr,
    input  logic              rValid,
    output logic              rReady,
    input  logic [31:0]       rData,
    input  logic [1:0]        rResp
);

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  aw_valid_q, aw_valid_d;
    logic                  w_valid_q, w_valid_d;
    logic                  b_ready_q, b_ready_d;
    logic                  ar_valid_q, ar_valid_d;
    logic                  r_ready_q, r_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0]     aw_addr_q, aw_addr_d;
    logic [ADDR_W-1:0]     ar_addr_q, ar_addr_d;
    logic [31:0]           w_data_q, w_data_d;
    logic [3:0]            w_strb_q, w_strb_d;
    logic [31:0]           rsp_data_q, rsp_data_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic [TIMEOUT_W-1:0]  wdog_q, wdog_d;
    logic                  err_q, err_d;

    logic              cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, any_axi_hs, waiting;
    logic [ADDR_W-1:0] cmd_addr_aligned;

    assign cmd_hs     = cmdValid & cmd_ready_q;
    assign aw_hs      = aw_valid_q & awReady;
    assign w_hs       = w_valid_q & wReady;
    assign b_hs       = bValid & b_ready_q;
    assign ar_hs      = ar_valid_q & arReady;
    assign r_hs       = rValid & r_ready_q;
    assign any_axi_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;
    assign waiting    = (state_q == ST_WR) || (state_q == ST_WB) ||
                        (state_q == ST_RA) || (state_q == ST_RD);

    assign cmd_addr_aligned = cmdAddr & ~ADDR_W'(3);

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a latch.
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        b_ready_d   = b_ready_q;
        ar_valid_d  = ar_valid_q;
        r_ready_d   = r_ready_q;
        rsp_valid_d = rsp_valid_q;
        aw_addr_d   = aw_addr_q;
        ar_addr_d   = ar_addr_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_hs) begin
                    cmd_ready_d = 1'b0;
                    if (cmdWrite) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        aw_addr_d  = cmd_addr_aligned;
                        w_data_d   = cmdData;
                        w_strb_d   = cmdStrb;
                        state_d    = ST_WR;
                    end else begin
                        ar_valid_d = 1'b1;
                        ar_addr_d  = cmd_addr_aligned;
                        state_d    = ST_RA;
                    end
                end
            end
            ST_WR: begin
                // AW and W retire independently; B is only accepted once both are gone.
                if (aw_hs) aw_valid_d = 1'b0;
                if (w_hs)  w_valid_d  = 1'b0;
                if (!aw_valid_d && !w_valid_d) begin
                    b_ready_d = 1'b1;
                    state_d   = ST_WB;
                end
            end
            ST_WB: begin
                if (b_hs) begin
                    b_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_resp_d  = bResp;
                    state_d     = ST_RSP;
                end
            end
            ST_RA: begin
                if (ar_hs) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = ST_RD;
                end
            end
            ST_RD: begin
                if (r_hs) begin
                    r_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rData;
                    rsp_resp_d  = rResp;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rspReady) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Watchdog only observes; a saturated counter never aborts the transaction.
    always_comb begin
        wdog_d = '0;
        if (waiting && !any_axi_hs) begin
            wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + TIMEOUT_W'(1);
        end
        err_d = err_q;
        if (errClr) begin
            err_d = 1'b0;
        end else if (wdog_d == '1) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            aw_addr_q   <= '0;
            ar_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= RESP_OKAY;
            wdog_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            b_ready_q   <= b_ready_d;
            ar_valid_q  <= ar_valid_d;
            r_ready_q   <= r_ready_d;
            rsp_valid_q <= rsp_valid_d;
            aw_addr_q   <= aw_addr_d;
            ar_addr_q   <= ar_addr_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
            wdog_q      <= wdog_d;
            err_q       <= err_d;
        end
    end

    assign cmdReady   = cmd_ready_q;
    assign awValid    = aw_valid_q;
    assign awAddr     = aw_addr_q;
    assign wValid     = w_valid_q;
    assign wData      = w_data_q;
    assign wStrb      = w_strb_q;
    assign bReady     = b_ready_q;
    assign arValid    = ar_valid_q;
    assign arAddr     = ar_addr_q;
    assign rReady     = r_ready_q;
    assign rspValid   = rsp_valid_q;
    assign rspData    = rsp_data_q;
    assign rspResp    = rsp_resp_q;
    assign errTimeout = err_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Randomized scoreboard bench for axil_cmd_master against a behavioural memory responder.
module tb_axil_cmd_master;
    import axil_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int TIMEOUT_W = 4;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              cmdValid = 1'b0, cmdReady, cmdWrite = 1'b0;
    logic [ADDR_W-1:0] cmdAddr = '0;
    logic [31:0]       cmdData = '0;
    logic [3:0]        cmdStrb = '0;
    logic              rspValid, rspReady = 1'b0;
    logic [31:0]       rspData;
    logic [1:0]        rspResp;
    logic              errTimeout, errClr = 1'b0;
    logic              awValid, awReady, wValid, wReady, bValid, bReady;
    logic              arValid, arReady, rValid, rReady;
    logic [ADDR_W-1:0] awAddr, arAddr;
    logic [31:0]       wData, rData;
    logic [3:0]        wStrb;
    logic [1:0]        bResp, rResp;

    always #5 aclk = ~aclk;

    axil_cmd_master #(.ADDR_W(ADDR_W), .TIMEOUT_W(TIMEOUT_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
        .cmdAddr(cmdAddr), .cmdData(cmdData), .cmdStrb(cmdStrb),
        .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspResp(rspResp),
        .errTimeout(errTimeout), .errClr(errClr),
        .awValid(awValid), .awReady(awReady), .awAddr(awAddr),
        .wValid(wValid), .wReady(wReady), .wData(wData), .wStrb(wStrb),
        .bValid(bValid), .bReady(bReady), .bResp(bResp),
        .arValid(arValid), .arReady(arReady), .arAddr(arAddr),
        .rValid(rValid), .rReady(rReady), .rData(rData), .rResp(rResp)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: word-addressed memory with byte strobes.
    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;
    rsp_t        sb_q[$];
    logic [31:0] ref_mem[int];
    logic [31:0] slave_mem[int];

    function automatic logic [31:0] ref_read(input int idx);
        if (ref_mem.exists(idx)) return ref_mem[idx];
        return '0;
    endfunction

    function automatic logic [31:0] slave_read(input int idx);
        if (slave_mem.exists(idx)) return slave_mem[idx];
        return '0;
    endfunction

    // Responder configuration, set by the stimulus before each command.
    int         aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    bit         aw_stuck = 0, w_stuck = 0;
    logic [1:0] cfg_resp = RESP_OKAY;
    int         rsp_mode = 0;  // 0: always ready, 1: random, 2: held low

    // Responder state: everything is sampled and driven on the falling edge.
    bit          aw_pend, w_pend, b_pend, ar_pend, r_pend;
    bit          aw_got, w_got, ar_got, bready_prev;
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic [31:0] aw_cap, w_cap, ar_cap;
    logic [3:0]  s_cap;

    initial begin
        awReady = 0; wReady = 0; bValid = 0; bResp = '0;
        arReady = 0; rValid = 0; rData = '0; rResp = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                awReady = 0; wReady = 0; bValid = 0; arReady = 0; rValid = 0;
                aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
                aw_got = 0; w_got = 0; ar_got = 0; bready_prev = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
                continue;
            end
            if (aw_pend) begin
                aw_pend = 0; aw_got = 1; awReady = 0;
                check("aw_valid_drop", awValid, 0);
            end
            if (w_pend) begin
                w_pend = 0; w_got = 1; wReady = 0;
                check("w_valid_drop", wValid, 0);
            end
            if (b_pend) begin
                logic [31:0] word;
                b_pend = 0; bValid = 0;
                word = slave_read(int'(aw_cap[15:2]));
                for (int i = 0; i < 4; i++) if (s_cap[i]) word[8*i +: 8] = w_cap[8*i +: 8];
                slave_mem[int'(aw_cap[15:2])] = word;
                aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
                check("b_ready_drop", bReady, 0);
            end
            if (ar_pend) begin
                ar_pend = 0; ar_got = 1; arReady = 0;
                check("ar_valid_drop", arValid, 0);
            end
            if (r_pend) begin
                r_pend = 0; rValid = 0; ar_got = 0; ar_wait = 0; r_wait = 0;
                check("r_ready_drop", rReady, 0);
            end

            if (awValid && !aw_got && !aw_stuck) begin
                if (aw_wait >= aw_delay) awReady = 1; else aw_wait++;
            end
            if (wValid && !w_got && !w_stuck) begin
                if (w_wait >= w_delay) wReady = 1; else w_wait++;
            end
            if (aw_got && w_got && !bValid) begin
                if (b_wait >= b_delay) begin bValid = 1; bResp = cfg_resp; end else b_wait++;
            end
            if (bReady && !bready_prev) check("b_ready_after_aw_w", aw_got && w_got, 1);
            bready_prev = bReady;
            if (arValid && !ar_got) begin
                if (ar_wait >= ar_delay) arReady = 1; else ar_wait++;
            end
            if (ar_got && !rValid) begin
                if (r_wait >= r_delay) begin
                    rValid = 1; rResp = cfg_resp; rData = slave_read(int'(ar_cap[15:2]));
                end else r_wait++;
            end

            if (awValid && awReady) begin aw_pend = 1; aw_cap = awAddr; end
            if (wValid && wReady)   begin w_pend = 1; w_cap = wData; s_cap = wStrb; end
            if (bValid && bReady)   b_pend = 1;
            if (arValid && arReady) begin ar_pend = 1; ar_cap = arAddr; end
            if (rValid && rReady)   r_pend = 1;
        end
    end

    // Response-side ready, driven just after the rising edge.
    initial forever begin
        @(posedge aclk);
        #1;
        case (rsp_mode)
            0:       rspReady = 1'b1;
            1:       rspReady = 1'($urandom_range(0, 1));
            default: rspReady = 1'b0;
        endcase
    end

    // Monitor: every response handshake pops and compares one expectation.
    initial forever begin
        @(negedge aclk);
        if (aresetn && rspValid && rspReady) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                check("rsp_data", rspData, e.data);
                check("rsp_resp", rspResp, e.resp);
            end
        end
    end

    task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
        aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
    endtask

    // Called on a falling edge; returns on the falling edge after the accept.
    task automatic issue_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] resp);
        int          n;
        int          idx;
        logic [31:0] word;
        rsp_t        e;
        n = 0;
        idx = int'(addr[15:2]);
        cfg_resp = resp;
        cmdValid = 1; cmdWrite = wr; cmdAddr = addr; cmdData = data; cmdStrb = strb;
        while (!cmdReady && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (!cmdReady) begin
            check("cmd_accept_timeout", 0, 1);
            cmdValid = 0;
            return;
        end
        if (wr) begin
            word = ref_read(idx);
            for (int i = 0; i < 4; i++) if (strb[i]) word[8*i +: 8] = data[8*i +: 8];
            ref_mem[idx] = word;
            e.data = '0;
        end else begin
            e.data = ref_read(idx);
        end
        e.resp = resp;
        sb_q.push_back(e);
        @(negedge aclk);
        cmdValid = 0;
        check("cmd_ready_drop", cmdReady, 0);
        if (wr) begin
            check("aw_w_valid_latency", {awValid, wValid, arValid}, 3'b110);
            check("aw_addr", awAddr, addr & 32'hFFFF_FFFC);
            check("w_data", wData, data);
            check("w_strb", wStrb, strb);
        end else begin
            check("ar_valid_latency", {awValid, wValid, arValid}, 3'b001);
            check("ar_addr", arAddr, addr & 32'hFFFF_FFFC);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge aclk);
            n++;
        end
        check("rsp_pending", sb_q.size(), 0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, |{cmdReady, rspValid, rspData, rspResp, errTimeout, awValid, awAddr,
                      wValid, wData, wStrb, bReady, arValid, arAddr, rReady}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: bench did not reach its end");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] held_data;
        logic [1:0]  held_resp;
        bit          stable;
        int          cnt;
        int          n;

        repeat (3) @(negedge aclk);
        check_all_zero("reset_outputs");
        aresetn = 1;
        @(negedge aclk);
        check("cmd_ready_after_reset", cmdReady, 1);

        set_delays(0, 0, 0, 0, 0);
        issue_cmd(1, 32'h10, 32'hDEADBEEF, 4'hF, RESP_OKAY);
        wait_done();
        issue_cmd(0, 32'h13, '0, '0, RESP_OKAY);
        wait_done();

        set_delays(3, 0, 1, 0, 0);
        issue_cmd(1, 32'h20, 32'h1234_5678, 4'hF, RESP_OKAY);
        wait_done();
        set_delays(2, 2, 0, 0, 0);
        issue_cmd(1, 32'h21, 32'hAABB_CCDD, 4'b0101, RESP_OKAY);
        wait_done();
        set_delays(0, 3, 2, 2, 3);
        issue_cmd(1, 32'h24, 32'hCAFE_F00D, 4'hC, RESP_OKAY);
        wait_done();
        issue_cmd(0, 32'h20, '0, '0, RESP_OKAY);
        wait_done();

        set_delays(1, 0, 0, 1, 2);
        issue_cmd(0, 32'h40, '0, '0, RESP_SLVERR);
        wait_done();
        check("no_timeout_after_slverr", errTimeout, 0);
        issue_cmd(1, 32'h44, 32'h0BAD_CAFE, 4'hF, RESP_OKAY);
        wait_done();
        issue_cmd(0, 32'h46, '0, '0, RESP_OKAY);
        wait_done();

        rsp_mode = 2;
        set_delays(0, 0, 0, 0, 0);
        issue_cmd(1, 32'h30, 32'h5555_AAAA, 4'hF, RESP_DECERR);
        n = 0;
        while (!rspValid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("stall_rsp_valid", rspValid, 1);
        held_data = rspData;
        held_resp = rspResp;
        stable = 1;
        cmdValid = 1; cmdWrite = 0; cmdAddr = 32'h30;
        repeat (20) begin
            @(negedge aclk);
            if (cmdReady || !rspValid || rspData !== held_data || rspResp !== held_resp) stable = 0;
        end
        check("stall_stable", stable, 1);
        rsp_mode = 0;
        @(negedge aclk);
        @(negedge aclk);
        check("cmd_ready_after_release", {cmdReady, rspValid}, 2'b10);
        issue_cmd(0, 32'h30, '0, '0, RESP_OKAY);
        wait_done();

        for (int t = 0; t < 40; t++) begin
            bit          wr;
            logic [31:0] addr;
            logic [1:0]  resp;
            int          r;
            wr   = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            r    = $urandom_range(0, 7);
            resp = (r < 5) ? RESP_OKAY : (r == 5) ? RESP_EXOKAY : (r == 6) ? RESP_SLVERR : RESP_DECERR;
            set_delays($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                       $urandom_range(0, 4), $urandom_range(0, 4));
            rsp_mode = $urandom_range(0, 1);
            issue_cmd(wr, addr, $urandom, 4'($urandom_range(0, 15)), resp);
            wait_done();
        end
        rsp_mode = 0;
        check("no_timeout_random", errTimeout, 0);

        aw_stuck = 1;
        w_stuck  = 1;
        issue_cmd(1, 32'h80, 32'h7777_7777, 4'hF, RESP_OKAY);
        cnt = 1;
        while (!errTimeout && cnt < 40) begin
            @(negedge aclk);
            if (!errTimeout) cnt++;
        end
        check("timeout_stall_cycles", cnt, 15);
        check("aw_valid_during_timeout", awValid, 1);
        errClr = 1;
        @(negedge aclk);
        check("err_clr_priority", errTimeout, 0);
        errClr = 0;
        @(negedge aclk);
        check("err_resets_while_stalled", errTimeout, 1);

        #2;
        aresetn = 0;
        #1;
        check_all_zero("async_reset_outputs");
        sb_q.delete();
        ref_mem.delete(int'(32'h80 >> 2));
        aw_stuck = 0;
        w_stuck  = 0;
        @(negedge aclk);
        @(negedge aclk);
        #2;
        aresetn = 1;
        @(negedge aclk);
        check("cmd_ready_after_reset2", cmdReady, 1);
        set_delays(1, 0, 0, 0, 1);
        issue_cmd(1, 32'h84, 32'h1357_9BDF, 4'hF, RESP_OKAY);
        wait_done();
        issue_cmd(0, 32'h84, '0, '0, RESP_OKAY);
        wait_done();
        check("no_timeout_final", errTimeout, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
